// File: rtl/conv_core_pkg.sv
// Shared conv_core constants and the tag carried alongside each multiplier op.
package conv_core_pkg;

  localparam int NREQ    = 4;
  localparam int DATA    = 16;
  localparam int PW      = 2 * (DATA - 1) + 1;
  localparam int MUL_LAT = 3;
  localparam int IDW     = $clog2(NREQ);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after ptr.
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant
);

  logic found;
  int   idx;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_share_arb.sv
// Time-shares one pipelined multiplier among NREQ requesters and routes products home.
// Define MUL_ARB_PERF_EN to add the perf_clr/perf_issue/perf_stall counter ports.
module mul_share_arb #(
  parameter int NREQ    = conv_core_pkg::NREQ,
  parameter int DATA    = conv_core_pkg::DATA,
  parameter int PW      = conv_core_pkg::PW,
  parameter int MUL_LAT = conv_core_pkg::MUL_LAT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DATA-1:0] req_a,
  input  logic [NREQ*DATA-1:0] req_b,
  output logic [DATA-1:0]      mul_a,
  output logic [DATA-1:0]      mul_b,
  input  logic [PW-1:0]        mul_p,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [NREQ*PW-1:0]   rsp_data,
  output logic                 busy
`ifdef MUL_ARB_PERF_EN
  ,
  input  logic                 perf_clr,
  output logic [31:0]          perf_issue,
  output logic [31:0]          perf_stall
`endif
);

  import conv_core_pkg::*;

  logic [NREQ-1:0] owed;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] accept;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  grant_id;
  logic            grant_any;
  tag_t            tag_q [MUL_LAT+1];

  assign eligible = req_valid & ~owed;
  assign accept   = rsp_valid & rsp_ready;

  rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_rr_arb (
    .req   (eligible),
    .ptr   (ptr),
    .grant (grant)
  );

  // Registers are all in reset anyway; the gate keeps req_ready low while rst_n is held.
  assign req_ready = grant & {NREQ{rst_n}};
  assign grant_any = |grant;

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_id = IDW'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a <= '0;
      mul_b <= '0;
      ptr   <= '0;
      owed  <= '0;
      // NOTE: the tag pipe must be reset; a stale vld would write a bogus result after reset.
      for (int s = 0; s <= MUL_LAT; s++) tag_q[s] <= '0;
    end else begin
      mul_a <= grant_any ? req_a[int'(grant_id)*DATA +: DATA] : '0;
      mul_b <= grant_any ? req_b[int'(grant_id)*DATA +: DATA] : '0;
      if (grant_any) begin
        ptr <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + IDW'(1);
      end
      owed <= (owed | grant) & ~accept;
      tag_q[0].vld <= grant_any;
      tag_q[0].id  <= grant_id;
      for (int s = 1; s <= MUL_LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  // Last tag stage lines up with the product of the op it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= rsp_valid & ~rsp_ready;
      if (tag_q[MUL_LAT].vld) begin
        rsp_valid[tag_q[MUL_LAT].id]                  <= 1'b1;
        rsp_data[int'(tag_q[MUL_LAT].id)*PW +: PW] <= mul_p;
      end
    end
  end

  always_comb begin
    busy = |rsp_valid;
    for (int s = 0; s <= MUL_LAT; s++) busy = busy | tag_q[s].vld;
  end

`ifdef MUL_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue <= '0;
      perf_stall <= '0;
    end else if (perf_clr) begin
      perf_issue <= '0;
      perf_stall <= '0;
    end else begin
      if (grant_any && perf_issue != 32'hFFFF_FFFF) perf_issue <= perf_issue + 32'd1;
      if (|req_valid && !grant_any && perf_stall != 32'hFFFF_FFFF) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb: transaction-level model plus directed scenarios.
module tb_mul_share_arb;

  localparam int NREQ    = 4;
  localparam int DATA    = 16;
  localparam int PW      = 31;
  localparam int MUL_LAT = 3;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*DATA-1:0] req_a;
  logic [NREQ*DATA-1:0] req_b;
  logic [DATA-1:0]      mul_a;
  logic [DATA-1:0]      mul_b;
  logic [PW-1:0]        mul_p;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [NREQ*PW-1:0]   rsp_data;
  logic                 busy;
`ifdef MUL_ARB_PERF_EN
  logic                 perf_clr;
  logic [31:0]          perf_issue;
  logic [31:0]          perf_stall;
`endif

  int n_checks = 0;
  int n_err    = 0;

  mul_share_arb #(.NREQ(NREQ), .DATA(DATA), .PW(PW), .MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
`ifdef MUL_ARB_PERF_EN
    ,
    .perf_clr   (perf_clr),
    .perf_issue (perf_issue),
    .perf_stall (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Sign-magnitude product; a zero magnitude never carries a sign.
  function automatic logic [PW-1:0] fixmul(input logic [DATA-1:0] a, input logic [DATA-1:0] b);
    logic [PW-2:0] mag;
    logic          s;
    mag = (PW-1)'(a[DATA-2:0]) * (PW-1)'(b[DATA-2:0]);
    s   = (mag != '0) ? (a[DATA-1] ^ b[DATA-1]) : 1'b0;
    return {s, mag};
  endfunction

  // Multiplier stand-in: MUL_LAT register stages from mul_a/mul_b to mul_p.
  logic [PW-1:0] mp1 = '0;
  logic [PW-1:0] mp2 = '0;
  initial mul_p = '0;
  always @(posedge clk) begin
    mp1   <= fixmul(mul_a, mul_b);
    mp2   <= mp1;
    mul_p <= mp2;
  end

  // Transaction model: each granted op becomes visible MUL_LAT+2 cycles after its grant cycle.
  bit              m_owed [NREQ];
  int              m_due  [NREQ];
  logic [PW-1:0]   m_res  [NREQ];
  int              m_ptr;
  logic [DATA-1:0] m_mul_a;
  logic [DATA-1:0] m_mul_b;
  int              cyc;
`ifdef MUL_ARB_PERF_EN
  longint          m_issue;
  longint          m_stall;
`endif

  initial cyc = 0;

  always @(negedge clk) begin : cmp
    int              g;
    int              idx;
    logic [NREQ-1:0] e_rdy;
    logic [NREQ-1:0] e_rv;
    logic            e_busy;
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        m_owed[i] = 1'b0;
        m_due[i]  = 0;
        m_res[i]  = '0;
      end
      m_ptr   = 0;
      m_mul_a = '0;
      m_mul_b = '0;
`ifdef MUL_ARB_PERF_EN
      m_issue = 0;
      m_stall = 0;
`endif
      check($sformatf("rst_req_ready@%0d", cyc), 64'(req_ready), 64'd0);
      check($sformatf("rst_rsp_valid@%0d", cyc), 64'(rsp_valid), 64'd0);
      check($sformatf("rst_rsp_data@%0d", cyc), 64'(rsp_data[63:0]), 64'd0);
      check($sformatf("rst_mul_a@%0d", cyc), 64'(mul_a), 64'd0);
      check($sformatf("rst_busy@%0d", cyc), 64'(busy), 64'd0);
    end else begin
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[idx] && !m_owed[idx]) g = idx;
      end
      e_rdy  = '0;
      e_rv   = '0;
      e_busy = 1'b0;
      if (g >= 0) e_rdy[g] = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        e_rv[i] = m_owed[i] && (cyc >= m_due[i]);
        e_busy  = e_busy | m_owed[i];
      end
      check($sformatf("req_ready@%0d", cyc), 64'(req_ready), 64'(e_rdy));
      check($sformatf("rsp_valid@%0d", cyc), 64'(rsp_valid), 64'(e_rv));
      check($sformatf("busy@%0d", cyc), 64'(busy), 64'(e_busy));
      check($sformatf("mul_a@%0d", cyc), 64'(mul_a), 64'(m_mul_a));
      check($sformatf("mul_b@%0d", cyc), 64'(mul_b), 64'(m_mul_b));
      for (int i = 0; i < NREQ; i++) begin
        if (e_rv[i]) check($sformatf("rsp_data%0d@%0d", i, cyc), 64'(rsp_data[i*PW +: PW]), 64'(m_res[i]));
      end
`ifdef MUL_ARB_PERF_EN
      check($sformatf("perf_issue@%0d", cyc), 64'(perf_issue), 64'(m_issue));
      check($sformatf("perf_stall@%0d", cyc), 64'(perf_stall), 64'(m_stall));
      if (g >= 0) m_issue++;
      else if (|req_valid) m_stall++;
`endif
      for (int i = 0; i < NREQ; i++) begin
        if (e_rv[i] && rsp_ready[i]) m_owed[i] = 1'b0;
      end
      if (g >= 0) begin
        m_owed[g] = 1'b1;
        m_due[g]  = cyc + MUL_LAT + 2;
        m_res[g]  = fixmul(req_a[g*DATA +: DATA], req_b[g*DATA +: DATA]);
        m_mul_a   = req_a[g*DATA +: DATA];
        m_mul_b   = req_b[g*DATA +: DATA];
        m_ptr     = (g + 1) % NREQ;
      end else begin
        m_mul_a = '0;
        m_mul_b = '0;
      end
    end
    cyc++;
  end

  task automatic drain();
    bit ok;
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = '1;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      ok = !busy;
    end
    check("drain_idle", 64'(ok), 64'd1);
  endtask

  task automatic run_single(input int i, input logic [DATA-1:0] a, input logic [DATA-1:0] b,
                            input logic [PW-1:0] exp_p, input string name);
    bit ok;
    int lat;
    @(posedge clk); #1;
    req_a[i*DATA +: DATA] = a;
    req_b[i*DATA +: DATA] = b;
    req_valid[i] = 1'b1;
    rsp_ready[i] = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = req_ready[i];
    end
    check({name, "_grant"}, 64'(ok), 64'd1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    ok  = 1'b0;
    lat = 0;
    while (!ok && lat < 20) begin
      @(negedge clk);
      lat++;
      ok = rsp_valid[i];
    end
    check({name, "_latency"}, 64'(lat), 64'(MUL_LAT + 2));
    check({name, "_data"}, 64'(rsp_data[i*PW +: PW]), 64'(exp_p));
    @(posedge clk); #1;
    rsp_ready[i] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[i] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int   ids [8];
    int   n;
    int   t;
    int   others;
    int   gcyc [3];
    logic [PW-1:0] held;
    bit   ok;

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;
`ifdef MUL_ARB_PERF_EN
    perf_clr  = 1'b0;
`endif

    // Hand-computed pins on the reference multiplier.
    check("model_pos",  64'(fixmul(16'h0100, 16'h0200)), 64'h0002_0000);
    check("model_neg",  64'(fixmul(16'h8100, 16'h0200)), 64'h4002_0000);
    check("model_zero", 64'(fixmul(16'h0000, 16'h8200)), 64'h0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_single(0, 16'h0100, 16'h0200, 31'h0002_0000, "single");
    run_single(1, 16'h8100, 16'h0200, 31'h4002_0000, "sign_neg");
    run_single(3, 16'h0000, 16'h8200, 31'h0000_0000, "sign_zero");

    // Fairness: everyone valid, results consumed at once.
    drain();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*DATA +: DATA] = DATA'($urandom);
      req_b[i*DATA +: DATA] = DATA'($urandom);
    end
    req_valid = '1;
    n = 0;
    t = 0;
    while (n < 8 && t < 60) begin
      @(negedge clk);
      t++;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          ids[n] = i;
          n++;
        end
      end
    end
    check("fair_count", 64'(n), 64'd8);
    for (int k = 1; k < 8; k++) begin
      if (k < n) check($sformatf("fair_order%0d", k), 64'(ids[k]), 64'((ids[0] + k) % NREQ));
    end

    // Hold: requester 2 does not consume for 10 cycles while the others keep flowing.
    drain();
    @(posedge clk); #1;
    rsp_ready = 4'b1011;
    req_valid = '1;
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      ok = rsp_valid[2];
    end
    check("hold_arrive", 64'(ok), 64'd1);
    held   = rsp_data[2*PW +: PW];
    others = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("hold_valid%0d", k), 64'(rsp_valid[2]), 64'd1);
      check($sformatf("hold_data%0d", k), 64'(rsp_data[2*PW +: PW]), 64'(held));
      check($sformatf("hold_noready%0d", k), 64'(req_ready[2]), 64'd0);
      if ((req_ready & 4'b1011) != '0) others++;
    end
    check("hold_others_granted", 64'(others > 0), 64'd1);

    // Back-to-back: requester 1 re-granted the cycle after each accept.
    drain();
    @(posedge clk); #1;
    req_a[DATA +: DATA] = 16'h1234;
    req_b[DATA +: DATA] = 16'h8765;
    req_valid[1] = 1'b1;
    n = 0;
    t = 0;
    while (n < 3 && t < 60) begin
      @(negedge clk);
      t++;
      if (req_ready[1]) begin
        gcyc[n] = t;
        n++;
      end
    end
    check("b2b_count", 64'(n), 64'd3);
    if (n == 3) begin
      check("b2b_gap1", 64'(gcyc[1] - gcyc[0]), 64'(MUL_LAT + 3));
      check("b2b_gap2", 64'(gcyc[2] - gcyc[1]), 64'(MUL_LAT + 3));
    end

    // Random traffic against the model.
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk); #1;
      req_valid = NREQ'($urandom);
      rsp_ready = NREQ'($urandom | $urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_a[i*DATA +: DATA] = ($urandom_range(0, 7) == 0) ? '0 : DATA'($urandom);
        req_b[i*DATA +: DATA] = ($urandom_range(0, 7) == 0) ? '0 : DATA'($urandom);
      end
    end

    // Reset with three ops in flight.
    drain();
    @(posedge clk); #1;
    rsp_ready = '0;
    req_valid = 4'b0111;
    n = 0;
    t = 0;
    while (n < 3 && t < 20) begin
      @(negedge clk);
      t++;
      if (|req_ready) n++;
    end
    check("rst_inflight_issued", 64'(n), 64'd3);
    @(posedge clk); #1;
    rst_n     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    check("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_rsp_valid%0d", k), 64'(rsp_valid), 64'd0);
      check($sformatf("post_rst_busy%0d", k), 64'(busy), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
